// File: rtl/int_to_fp_converter.sv
// Sequential 16-bit signed integer to fp16 converter: one-bit-per-cycle
// normalization followed by a round-to-nearest-even step.
module int_to_fp_converter (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] x,
  output logic               busy,
  output logic               done,
  output logic        [15:0] r,
  output logic               negative,
  output logic               zero,
  output logic               inexact
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [15:0] x_u;
  logic [15:0] x_mag;
  logic        s_q;
  logic [15:0] m_q;
  logic [4:0]  e_q;
  logic [15:0] rnd;

  // Builds {sign, exponent, mantissa} from a normalized magnitude (m[15]=1).
  // A mantissa carry-out bumps the exponent; e never exceeds 30 here because
  // the only magnitude reaching e=30 (0x8000) has no round bits.
  function automatic logic [15:0] round_rne(input logic        s,
                                            input logic [15:0] m,
                                            input logic [4:0]  e);
    logic [9:0]  mant;
    logic        g;
    logic        st;
    logic        up;
    logic [10:0] sum;
    logic [4:0]  ex;
    mant = m[14:5];
    g    = m[4];
    st   = |m[3:0];
    up   = g & (st | mant[0]);
    sum  = {1'b0, mant} + {10'd0, up};
    ex   = e + {4'd0, sum[10]};
    return {s, ex, sum[9:0]};
  endfunction

  function automatic logic round_inexact(input logic [15:0] m);
    return m[4] | (|m[3:0]);
  endfunction

  assign x_u   = x;
  // -32768 negates to itself, which read as unsigned is the correct 0x8000.
  assign x_mag = x_u[15] ? (~x_u + 16'd1) : x_u;
  assign rnd   = round_rne(s_q, m_q, e_q);

  assign busy = (state == NORM) || (state == ROUND);
  assign done = (state == DONE);

  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (x_u == 16'd0) ? DONE : NORM;
        end else begin
          state_nxt = IDLE;
        end
      end
      NORM:    state_nxt = m_q[15] ? ROUND : NORM;
      ROUND:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      r        <= 16'h0000;
      negative <= 1'b0;
      zero     <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && (x_u == 16'd0)) begin
        r        <= 16'h0000;
        negative <= 1'b0;
        zero     <= 1'b1;
        inexact  <= 1'b0;
      end else if (state == ROUND) begin
        r        <= rnd;
        negative <= s_q;
        zero     <= 1'b0;
        inexact  <= round_inexact(m_q);
      end
    end
  end

  // Operand working registers need no reset: they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      s_q <= x_u[15];
      m_q <= x_mag;
      e_q <= 5'd30;
    end else if ((state == NORM) && !m_q[15]) begin
      m_q <= m_q << 1;
      e_q <= e_q - 5'd1;
    end
  end

endmodule
